mesh_output_collector: RTL

- Sits on the south edge of the systolic mesh, downstream of the PE columns that the input stage feeds from the north and west.
- Captures the skewed per-column results leaving the mesh into one FIFO per column (lane).
- Re-aligns the results into complete rows and streams them to the host/memory side, one 32-bit word per beat, over a valid/ready handshake.
- Signals completion after a programmed number of rows has been delivered.

---
 rtl/mesh_pkg.sv | 16 +
 rtl/mesh_output_collector_if.sv | 25 ++
 rtl/mesh_output_collector_lane_fifo.sv | 60 ++++++
 rtl/mesh_output_collector.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared types for the systolic mesh south-edge output collector.
// Holds the word width, lane count, lane-word type and collector state.
package mesh_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } col_state_e;

endpackage

// File: rtl/mesh_output_collector_if.sv
// Row stream from the collector towards the host/memory side.
// Valid/ready handshake with a last-of-row marker.
interface mesh_output_collector_if;
  import mesh_pkg::*;

  word_t out_data;
  logic  out_valid;
  logic  out_ready;
  logic  out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/mesh_output_collector_lane_fifo.sv
// Per-lane result FIFO; pointers carry one extra wrap bit.
// A full FIFO still accepts a push when it pops in the same cycle.
module lane_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + ONE;
      if (do_pop)  rd_d = rd_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mesh_output_collector.sv
// Collects skewed mesh column results and streams them out as aligned rows.
// Define MESH_OUTCOL_OVF_ERR_EN to build sticky lane-overflow detection on err.
module mesh_output_collector
  import mesh_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ROWS_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ROWS_W-1:0]       row_count,
  input  word_t                   in_data [LANES],
  input  logic [LANES-1:0]        in_valid,
  mesh_output_collector_if.master stream,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0]     LAST_LANE = LW'(LANES - 1);
  localparam logic [LW-1:0]     ONE_L     = 1;
  localparam logic [ROWS_W-1:0] ONE_R     = 1;

  col_state_e        state_q, state_d;
  logic [ROWS_W-1:0] rows_left_q, rows_left_d;
  logic [ROWS_W-1:0] issue_left_q, issue_left_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              mid_q, mid_d;
  word_t             data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  word_t             dout [LANES];
  logic [LANES-1:0]  empty, full, push, pop;
  logic              flush, load, accept, row_go, avail;
  logic [LW-1:0]     cur;

  assign push  = (state_q == COLLECT) ? in_valid : '0;
  assign flush = (state_q == DONE);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_data[i]),
      .dout  (dout[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    rows_left_d  = rows_left_q;
    issue_left_d = issue_left_q;
    lane_d       = lane_q;
    mid_d        = mid_q;
    data_d       = data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    pop          = '0;

    load   = !valid_q || stream.out_ready;
    accept = valid_q && stream.out_ready;
    // Rows are only issued as many times as the job asked for.
    row_go = !mid_q && (state_q == COLLECT) && !(|empty) &&
             (issue_left_q != '0);
    avail  = mid_q || row_go;
    cur    = mid_q ? lane_q : '0;

    if (load) begin
      valid_d = avail;
      last_d  = 1'b0;
      if (avail) begin
        data_d   = dout[cur];
        last_d   = (cur == LAST_LANE);
        pop[cur] = 1'b1;
        if (cur == LAST_LANE) begin
          mid_d  = 1'b0;
          lane_d = '0;
        end else begin
          mid_d  = 1'b1;
          lane_d = cur + ONE_L;
        end
        if (row_go) issue_left_d = issue_left_q - ONE_R;
      end
    end

    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          rows_left_d  = row_count;
          issue_left_d = row_count;
          state_d      = (row_count == '0) ? DONE : COLLECT;
        end
      end
      (state_q == COLLECT): begin
        if (accept && last_q) begin
          rows_left_d = rows_left_q - ONE_R;
          if (rows_left_q == ONE_R) state_d = DONE;
        end
      end
      (state_q == DONE): state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rows_left_q  <= '0;
      issue_left_q <= '0;
      lane_q       <= '0;
      mid_q        <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rows_left_q  <= rows_left_d;
      issue_left_q <= issue_left_d;
      lane_q       <= lane_d;
      mid_q        <= mid_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
    end
  end

`ifdef MESH_OUTCOL_OVF_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && start) err_d = 1'b0;
    else if (|(push & full & ~pop)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_full;
  assign unused_full = ^full;
  assign err = 1'b0;
`endif

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign stream.out_last  = last_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
